// File: rtl/io_in_debounce_pkg.sv
// Shared constants and helpers for io_in conditioning.
// Holds default debounce/auto-repeat timings, counter width helper, lane map.
package io_cond_pkg;

   localparam int DEBOUNCE_STABLE_CYCLES = 1000;
   localparam int AUTOREPEAT_DELAY       = 50000;
   localparam int AUTOREPEAT_PERIOD      = 10000;

   // io_in lane mapping seen by the counter top
   localparam int RST_LANE  = 0;
   localparam int STEP_LANE = 1;

   // Smallest width w with 2**w > n (at least 1 bit)
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/io_in_debounce_lane.sv
// debounce_lane: one-bit two-flop synchroniser, stability counter, edge pulses.
// Ports: clk, rst (async high), raw (async input), level, rise, fall.
// Optional auto-repeat of rise while held high: IO_DEBOUNCE_AUTOREPEAT_EN.
module debounce_lane
   import io_cond_pkg::*;
#(
   parameter int STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES,
   parameter int CNT_W         = cnt_w(DEBOUNCE_STABLE_CYCLES)
`ifdef IO_DEBOUNCE_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY  = AUTOREPEAT_DELAY,
   parameter int REPEAT_PERIOD = AUTOREPEAT_PERIOD
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;
   logic             differ;
   logic             accept;
   logic             rpt_hit;

   assign differ = sync2 ^ level;
   assign accept = differ && (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= (accept & sync2) | rpt_hit;
         fall <= accept & ~sync2;
         if (!differ) begin
            cnt <= '0;
         end else if (accept) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

`ifdef IO_DEBOUNCE_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                            REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = cnt_w(RPT_MAX);
   localparam logic [RPT_W-1:0] D_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] P_LAST = RPT_W'(REPEAT_PERIOD - 1);

   logic [RPT_W-1:0] rcnt;
   logic             armed;

   // Any accepted transition (rise or fall) restarts the repeat timing,
   // so a repeat can never land on the fall edge.
   assign rpt_hit = level && !accept &&
                    (armed ? (rcnt == P_LAST) : (rcnt == D_LAST));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rcnt  <= '0;
         armed <= 1'b0;
      end else if (accept || !level) begin
         rcnt  <= '0;
         armed <= 1'b0;
      end else if (rpt_hit) begin
         rcnt  <= '0;
         armed <= 1'b1;
      end else begin
         rcnt <= rcnt + 1'b1;
      end
   end
`else
   assign rpt_hit = 1'b0;
`endif

endmodule

// File: rtl/io_in_debounce.sv
// io_in_debounce: synchronise and debounce WIDTH io_in bits, emit edge pulses.
// Ports: clk, rst (async high), raw_in, db_level, rise_pulse, fall_pulse.
// Optional auto-repeat on rise_pulse: IO_DEBOUNCE_AUTOREPEAT_EN.
module io_in_debounce
   import io_cond_pkg::*;
#(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES,
   parameter int CNT_W         = 16
`ifdef IO_DEBOUNCE_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY  = AUTOREPEAT_DELAY,
   parameter int REPEAT_PERIOD = AUTOREPEAT_PERIOD
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] db_level,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      debounce_lane #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .CNT_W         (CNT_W)
`ifdef IO_DEBOUNCE_AUTOREPEAT_EN
         ,
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
      ) u_lane (
         .clk   (clk),
         .rst   (rst),
         .raw   (raw_in[i]),
         .level (db_level[i]),
         .rise  (rise_pulse[i]),
         .fall  (fall_pulse[i])
      );
   end

endmodule
